i2c_write_master: RTL and testbench
===================================

I2C_WRITE_MASTER -- requirements
Module: i2c_write_master

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, meaning the iCLK frequency in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 20000, meaning the SCL bit rate in Hz.
REQ-003 SHALL derive QDIV = CLK_FREQ/(4*I2C_FREQ), the iCLK cycles per quarter-bit; QDIV SHALL be at least 2.
REQ-004 SHALL have port iCLK, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 SHALL have port iRST_N, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port iGO, input, 1 bit: transfer request, a level held by the host.
REQ-007 SHALL have port iDATA, input, 24 bits: {slave address with R/W bit, sub-address, data}, sent MSB first.
REQ-008 SHALL have port oEND, output, 1 bit: the transfer is complete.
REQ-009 SHALL have port oACK, output, 1 bit: 0 means all three bytes were ACKed; 1 means at least one NACK; valid while oEND=1.
REQ-010 SHALL have port oBUSY, output, 1 bit: a transfer is in progress.
REQ-011 SHALL have port I2C_SCLK, output, 1 bit: the I2C clock.
REQ-012 SHALL have port I2C_SDAT, inout, 1 bit: I2C data, open-drain; it is driven only 0 or Z.

Function
REQ-013 SHALL generate a quarter tick: a one-cycle pulse once every QDIV iCLK cycles.
REQ-014 SHALL run the quarter-tick counter only while oBUSY=1.
REQ-015 SHALL clear the quarter-tick counter to 0 on transfer start.
REQ-016 SHALL have the FSM states IDLE, START, BIT, STOP and DONE; all state advances SHALL occur on quarter ticks, except IDLE->START and DONE->IDLE.
REQ-017 IDLE: SCL=1, SDA released, oBUSY=0.
REQ-018 IDLE SHALL go to START in the cycle after it samples iGO=1 with oEND=0.
REQ-019 On the IDLE->START transition the block SHALL latch iDATA into a shift register; later changes to iDATA SHALL be ignored.
REQ-020 START SHALL last 2 quarters: q0 SDA=0 with SCL=1; q1 SCL=0.
REQ-021 BIT SHALL send 27 bit slots: 3 bytes, each 8 data bits followed by one ACK slot.
REQ-022 Each bit slot SHALL last 4 quarters: q0 SCL=0 and SDA set up; q1 SCL=1; q2 SCL=1; q3 SCL=0.
REQ-023 Data slots SHALL drive SDA=0 for a 0 bit and release SDA for a 1 bit.
REQ-024 ACK slots SHALL release SDA.
REQ-025 ACK slots SHALL sample I2C_SDAT on the q2 tick; a sampled 1 SHALL set a sticky NACK flag.
REQ-026 A NACK SHALL NOT abort the transfer; all 27 slots SHALL still be sent.
REQ-027 STOP SHALL last 3 quarters: q0 SCL=0, SDA=0; q1 SCL=1, SDA=0; q2 SCL=1, SDA released.
REQ-028 At the end of STOP the block SHALL enter DONE; oEND=1, oACK=NACK flag, oBUSY=0.
REQ-029 DONE SHALL hold oEND and oACK until iGO=0 is sampled; the next cycle SHALL clear oEND and return to IDLE. Holding iGO high SHALL NOT start a new transfer.
REQ-030 If iGO falls mid-transfer, the transfer SHALL complete, and oEND SHALL be high for exactly 1 cycle.
REQ-031 A transfer SHALL last 113 quarters, and oEND SHALL rise 113*QDIV+1 (±1) cycles after iGO is sampled.
REQ-032 The bit counter SHALL be 5 bits (0..26) and SHALL NOT wrap in BIT; reaching slot 26 q3 SHALL go to STOP.
REQ-033 SCL and SDA SHALL be driven from registers, so the outputs are glitch-free.

Reset
REQ-034 While iRST_N=0 the block SHALL be in IDLE with I2C_SCLK=1, I2C_SDAT=Z, oEND=0, oACK=0, oBUSY=0, and all counters at 0.
REQ-035 Reset mid-transfer SHALL release the bus immediately (asynchronously) with no STOP issued; after reset a new iGO SHALL start a clean transfer.

Verification (CLK_FREQ=400, I2C_FREQ=25, so QDIV=4)
REQ-036 iDATA=24'h729803, iGO=1, slave ACKs all bytes -> SDA bits 0111_0010,A,1001_1000,A,0000_0011,A are framed by START/STOP, oEND rises after 453±1 cycles, oACK=0.
REQ-037 Same transfer with the slave NACKing the address byte -> all 27 slots are still clocked, oEND=1, oACK=1.
REQ-038 iGO held high for 1000 cycles after oEND -> no second START; after iGO=0, oEND=0 on the next cycle; a new iGO=1 starts a fresh transfer and oACK reflects that transfer only.
REQ-039 iRST_N pulsed low during byte 1, bit 4 -> in the same cycle SCL=1, SDA=Z, oBUSY=0, oEND=0.
REQ-040 iDATA changed and iGO dropped during byte 0 -> the latched value is sent unchanged and oEND pulses high for 1 cycle.

Source files
------------

// File: rtl/i2c_write_master.sv
// Write-only I2C master: sends a START, three bytes from iDATA (each followed by an
// ACK slot), then a STOP. A NACK is recorded in oACK but never aborts the transfer.
module i2c_write_master #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iGO,
  input  logic [23:0] iDATA,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW = (QDIV > 2) ? $clog2(QDIV) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QDIV - 1);
  localparam logic [4:0] LAST_SLOT = 5'd26;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    BIT   = 3'd2,
    STOP  = 3'd3,
    DONE  = 3'd4
  } fsmState_t;

  fsmState_t   state_r, stateNx_s;
  logic [QW-1:0] qCnt_r;
  logic [1:0]  quarter_r, quarterNx_s;
  logic [4:0]  bitCnt_r, bitCntNx_s;
  logic [23:0] shift_r, shiftNx_s;
  logic        nack_r, nackNx_s;
  logic        scl_r, sclNx_s;
  logic        sdaLow_r, sdaLowNx_s;
  logic        end_r, endNx_s;
  logic        ack_r, ackNx_s;
  logic        busy_r, busyNx_s;
  logic        tick_s, start_s, sdaIn_s;

  // Slots 8, 17 and 26 are the ACK slots following each byte.
  function automatic logic isAckSlot(input logic [4:0] slot);
    return (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  endfunction

  assign tick_s   = busy_r && (qCnt_r == QMAX);
  assign sdaIn_s  = I2C_SDAT;
  assign I2C_SDAT = sdaLow_r ? 1'b0 : 1'bz;
  assign I2C_SCLK = scl_r;
  assign oEND     = end_r;
  assign oACK     = ack_r;
  assign oBUSY    = busy_r;

  // Quarter-bit timebase, restarted at every transfer start.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      qCnt_r <= '0;
    end else if (start_s) begin
      qCnt_r <= '0;
    end else if (busy_r) begin
      qCnt_r <= tick_s ? '0 : qCnt_r + {{(QW-1){1'b0}}, 1'b1};
    end else begin
      qCnt_r <= '0;
    end
  end

  // State, counters and the registered bus/status outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_r   <= IDLE;
      quarter_r <= 2'd0;
      bitCnt_r  <= 5'd0;
      shift_r   <= 24'd0;
      nack_r    <= 1'b0;
      scl_r     <= 1'b1;
      sdaLow_r  <= 1'b0;
      end_r     <= 1'b0;
      ack_r     <= 1'b0;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= stateNx_s;
      quarter_r <= quarterNx_s;
      bitCnt_r  <= bitCntNx_s;
      shift_r   <= shiftNx_s;
      nack_r    <= nackNx_s;
      scl_r     <= sclNx_s;
      sdaLow_r  <= sdaLowNx_s;
      end_r     <= endNx_s;
      ack_r     <= ackNx_s;
      busy_r    <= busyNx_s;
    end
  end

  // Next-state logic; everything except IDLE->START and DONE->IDLE waits for a tick.
  always_comb begin
    stateNx_s   = state_r;
    quarterNx_s = quarter_r;
    bitCntNx_s  = bitCnt_r;
    shiftNx_s   = shift_r;
    nackNx_s    = nack_r;
    start_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (iGO && !end_r) begin
          stateNx_s   = START;
          quarterNx_s = 2'd0;
          bitCntNx_s  = 5'd0;
          shiftNx_s   = iDATA;
          nackNx_s    = 1'b0;
          start_s     = 1'b1;
        end else begin
          stateNx_s = IDLE;
        end
      end
      START: begin
        if (!tick_s) begin
          stateNx_s = START;
        end else if (quarter_r == 2'd0) begin
          quarterNx_s = 2'd1;
        end else begin
          stateNx_s   = BIT;
          quarterNx_s = 2'd0;
        end
      end
      BIT: begin
        if (!tick_s) begin
          stateNx_s = BIT;
        end else if (quarter_r == 2'd3) begin
          quarterNx_s = 2'd0;
          if (bitCnt_r == LAST_SLOT) begin
            stateNx_s = STOP;
          end else begin
            bitCntNx_s = bitCnt_r + 5'd1;
            if (!isAckSlot(bitCnt_r)) begin
              shiftNx_s = {shift_r[22:0], 1'b0};
            end else begin
              shiftNx_s = shift_r;
            end
          end
        end else begin
          quarterNx_s = quarter_r + 2'd1;
          if ((quarter_r == 2'd2) && isAckSlot(bitCnt_r) && sdaIn_s) begin
            nackNx_s = 1'b1;
          end else begin
            nackNx_s = nack_r;
          end
        end
      end
      STOP: begin
        if (!tick_s) begin
          stateNx_s = STOP;
        end else if (quarter_r == 2'd2) begin
          stateNx_s   = DONE;
          quarterNx_s = 2'd0;
        end else begin
          quarterNx_s = quarter_r + 2'd1;
        end
      end
      DONE: begin
        if (!iGO) begin
          stateNx_s = IDLE;
        end else begin
          stateNx_s = DONE;
        end
      end
      default: begin
        stateNx_s   = IDLE;
        quarterNx_s = 2'd0;
      end
    endcase
  end

  // Bus levels decoded from the upcoming state so they change with it on the same edge.
  always_comb begin
    sclNx_s    = 1'b1;
    sdaLowNx_s = 1'b0;
    endNx_s    = 1'b0;
    ackNx_s    = 1'b0;
    busyNx_s   = 1'b0;
    case (stateNx_s)
      IDLE: begin
        sclNx_s = 1'b1;
      end
      START: begin
        sclNx_s    = (quarterNx_s == 2'd0);
        sdaLowNx_s = 1'b1;
        busyNx_s   = 1'b1;
      end
      BIT: begin
        sclNx_s  = (quarterNx_s == 2'd1) || (quarterNx_s == 2'd2);
        busyNx_s = 1'b1;
        if (isAckSlot(bitCntNx_s)) begin
          sdaLowNx_s = 1'b0;
        end else begin
          sdaLowNx_s = ~shiftNx_s[23];
        end
      end
      STOP: begin
        sclNx_s    = (quarterNx_s != 2'd0);
        sdaLowNx_s = (quarterNx_s != 2'd2);
        busyNx_s   = 1'b1;
      end
      DONE: begin
        endNx_s = 1'b1;
        ackNx_s = nackNx_s;
      end
      default: begin
        sclNx_s = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Randomized bench for i2c_write_master: every quarter-bit of the bus is compared
// against a quarter-by-quarter picture of the transfer built from the frame layout.
module tb_i2c_write_master;

  localparam int CLK_FREQ = 400;
  localparam int I2C_FREQ = 25;
  localparam int NQ = 113;

  logic        iCLK = 1'b0;
  logic        iRST_N;
  logic        iGO;
  logic [23:0] iDATA;
  logic        oEND, oACK, oBUSY, I2C_SCLK;
  wire         sdaBus;
  logic        slaveLow;

  int nChecks = 0;
  int nPass = 0;

  pullup (sdaBus);
  assign sdaBus = slaveLow ? 1'b0 : 1'bz;

  i2c_write_master #(.CLK_FREQ(CLK_FREQ), .I2C_FREQ(I2C_FREQ)) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .iGO(iGO), .iDATA(iDATA),
    .oEND(oEND), .oACK(oACK), .oBUSY(oBUSY),
    .I2C_SCLK(I2C_SCLK), .I2C_SDAT(sdaBus)
  );

  always #5 iCLK = ~iCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got === exp) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Expected SCL/SDA for quarter k of a transfer: 2 START, 27 slots of 4, 3 STOP.
  function automatic void expQuarter(input int k, input logic [23:0] d, input logic [2:0] nackMask,
                                     output logic scl, output logic sda);
    int s, q, b, pos;
    if (k < 2) begin
      scl = (k == 0);
      sda = 1'b0;
    end else if (k < 110) begin
      s = (k - 2) / 4;
      q = (k - 2) % 4;
      b = s / 9;
      pos = s % 9;
      scl = (q == 1) || (q == 2);
      if (pos == 8) sda = nackMask[b];
      else sda = d[23 - (b * 8 + pos)];
    end else begin
      scl = (k != 110);
      sda = (k == 112);
    end
  endfunction

  function automatic logic slaveAcks(input int k, input logic [2:0] nackMask);
    int s;
    if (k < 2 || k >= 110) return 1'b0;
    s = (k - 2) / 4;
    if (s % 9 != 8) return 1'b0;
    return !nackMask[s / 9];
  endfunction

  task automatic runXfer(input logic [23:0] d, input logic [2:0] nackMask, input bit dropGo,
                         input int abortQ, input int holdCycles);
    logic scl, sda;
    int lat;
    bit bad;
    iDATA = d;
    iGO = 1'b1;
    @(posedge iCLK);
    for (int k = 0; k < NQ; k++) begin
      #1;
      slaveLow = slaveAcks(k, nackMask);
      if (dropGo && k == 6) begin
        iGO = 1'b0;
        iDATA = $urandom;
      end
      @(posedge iCLK);
      @(posedge iCLK);
      #1;
      expQuarter(k, d, nackMask, scl, sda);
      chk("scl", I2C_SCLK, scl);
      chk("sda", sdaBus, sda);
      chk("busy", oBUSY, 1);
      chk("end_low", oEND, 0);
      if (k == abortQ) begin
        iRST_N = 1'b0;
        #1;
        chk("rst_scl", I2C_SCLK, 1);
        chk("rst_sda", sdaBus, 1);
        chk("rst_busy", oBUSY, 0);
        chk("rst_end", oEND, 0);
        chk("rst_ack", oACK, 0);
        slaveLow = 1'b0;
        iGO = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        chk("rst_hold_busy", oBUSY, 0);
        iRST_N = 1'b1;
        @(posedge iCLK);
        #1;
        return;
      end
      @(posedge iCLK);
      @(posedge iCLK);
    end
    lat = 452;
    #1;
    slaveLow = 1'b0;
    while (!oEND && lat < 458) begin
      @(posedge iCLK);
      #1;
      lat++;
    end
    chk("end_latency", {31'd0, (lat >= 452 && lat <= 454)}, 1);
    chk("oack", oACK, {31'd0, |nackMask});
    chk("busy_done", oBUSY, 0);
    chk("scl_done", I2C_SCLK, 1);
    chk("sda_done", sdaBus, 1);
    if (dropGo) begin
      @(posedge iCLK);
      #1;
      chk("end_pulse", oEND, 0);
    end else begin
      bad = 1'b0;
      repeat (holdCycles) begin
        @(posedge iCLK);
        #1;
        if (oBUSY !== 1'b0 || oEND !== 1'b1 || I2C_SCLK !== 1'b1 || sdaBus !== 1'b1) bad = 1'b1;
      end
      chk("no_restart", {31'd0, bad}, 0);
      iGO = 1'b0;
      @(posedge iCLK);
      #1;
      chk("end_clear", oEND, 0);
    end
    repeat (3) @(posedge iCLK);
    #1;
  endtask

  initial begin
    iRST_N = 1'b0;
    iGO = 1'b0;
    iDATA = 24'd0;
    slaveLow = 1'b0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("reset_scl", I2C_SCLK, 1);
    chk("reset_sda", sdaBus, 1);
    chk("reset_end", oEND, 0);
    chk("reset_ack", oACK, 0);
    chk("reset_busy", oBUSY, 0);
    iRST_N = 1'b1;
    @(posedge iCLK);
    #1;

    runXfer(24'h729803, 3'b000, 1'b0, -1, 10);
    runXfer(24'h729803, 3'b001, 1'b0, -1, 1000);
    runXfer(24'h729803, 3'b000, 1'b0, -1, 5);
    runXfer(24'($urandom), 3'($urandom), 1'b1, -1, 0);
    runXfer(24'($urandom), 3'b000, 1'b0, 55, 0);
    runXfer(24'($urandom), 3'($urandom), 1'b0, -1, 3);
    for (int i = 0; i < 4; i++) begin
      runXfer(24'($urandom), 3'($urandom), 1'($urandom), -1, 2);
    end

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
